// File: rtl/pwm_sample_capture.sv
// PWM decoder: measures high time and period between rising edges of an async pin and
// hands one sample per frame to the consumer through a 1-deep valid/ready register.
module pwm_sample_capture #(
  parameter int CNT_W      = 12,
  parameter int SAMPLE_W   = 8,
  parameter int TIMEOUT    = 1024,
  parameter int MIN_PERIOD = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                pwm_in,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic [CNT_W-1:0]    period_out,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  output logic                locked
);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MIN_C       = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] SAMPLE_SAT  = {{(CNT_W-SAMPLE_W){1'b0}}, {SAMPLE_W{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                s1_q, s2_q, s3_q;
  logic [CNT_W-1:0]    period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0]    high_cnt_q, high_cnt_d;
  logic [SAMPLE_W-1:0] sample_q;
  logic [CNT_W-1:0]    period_q;
  logic                valid_q;
  logic                overrun_q;
  logic                locked_q;

  logic                rise;
  logic                level;
  logic                emit;
  logic [SAMPLE_W-1:0] emit_sample;
  logic [CNT_W-1:0]    emit_period;
  logic                set_lock;
  logic                clr_lock;

  // Two flops for metastability, a third to find the rising edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise  = s2_q & ~s3_q;
  assign level = s2_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    emit         = 1'b0;
    emit_sample  = '0;
    emit_period  = '0;
    set_lock     = 1'b0;
    clr_lock     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        period_cnt_d = '0;
        high_cnt_d   = '0;
        if (rise) begin
          period_cnt_d = CNT_ONE;
          high_cnt_d   = CNT_ONE;
          state_d      = ST_MEASURE;
        end
      end

      ST_MEASURE: begin
        period_cnt_d = (period_cnt_q == CNT_MAX) ? CNT_MAX : period_cnt_q + CNT_ONE;
        if (level && (high_cnt_q != CNT_MAX)) begin
          high_cnt_d = high_cnt_q + CNT_ONE;
        end
        // An accepted edge takes priority over the timeout threshold in the same cycle.
        if (rise && (period_cnt_q >= MIN_C)) begin
          emit         = 1'b1;
          emit_sample  = (high_cnt_q > SAMPLE_SAT) ? {SAMPLE_W{1'b1}} : high_cnt_q[SAMPLE_W-1:0];
          emit_period  = period_cnt_q;
          period_cnt_d = CNT_ONE;
          high_cnt_d   = CNT_ONE;
          set_lock     = 1'b1;
        end else if (period_cnt_q >= TIMEOUT_C) begin
          state_d = ST_TIMEOUT;
        end
      end

      ST_TIMEOUT: begin
        emit         = 1'b1;
        emit_sample  = level ? {SAMPLE_W{1'b1}} : '0;
        emit_period  = '0;
        clr_lock     = 1'b1;
        period_cnt_d = '0;
        high_cnt_d   = '0;
        state_d      = ST_IDLE;
      end

      default: begin
        period_cnt_d = '0;
        high_cnt_d   = '0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // Output holding register: a new sample always overwrites; overrun flags a lost one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sample_q  <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      overrun_q <= emit & valid_q & ~sample_ready;
      if (emit) begin
        sample_q <= emit_sample;
        period_q <= emit_period;
        valid_q  <= 1'b1;
      end else if (valid_q && sample_ready) begin
        valid_q <= 1'b0;
      end
      if (set_lock) begin
        locked_q <= 1'b1;
      end else if (clr_lock) begin
        locked_q <= 1'b0;
      end
    end
  end

  assign sample_out   = sample_q;
  assign period_out   = period_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_pwm_sample_capture.sv
// Bench for pwm_sample_capture: frame table plus hand-built corner sequences, with a
// scoreboard queue checked whenever the consumer takes a sample.
module tb_pwm_sample_capture;

  logic        CLK = 1'b0;
  logic        RST;
  logic        pwm_in;
  logic        sample_ready;
  logic [7:0]  sample_out;
  logic [11:0] period_out;
  logic        sample_valid;
  logic        overrun;
  logic        locked;

  pwm_sample_capture dut (
    .CLK          (CLK),
    .RST          (RST),
    .pwm_in       (pwm_in),
    .sample_out   (sample_out),
    .period_out   (period_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .locked       (locked)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int high;
    int period;
    int exp_sample;
    int exp_period;
  } vec_t;

  typedef struct {
    int s;
    int p;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   ovr_cnt = 0;
  int   ovr0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int s, input int p);
    exp_t e;
    e.s = s;
    e.p = p;
    sb.push_back(e);
  endtask

  task automatic pin(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic frame(input int h, input int p);
    pin(1'b1, h);
    pin(1'b0, p - h);
  endtask

  // Consumer side: every take is matched against the oldest expected sample.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      if (overrun) ovr_cnt++;
      if (sample_valid && sample_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_sample", int'(sample_out), -1);
        end else begin
          e = sb.pop_front();
          chk("sample_out", int'(sample_out), e.s);
          chk("period_out", int'(period_out), e.p);
        end
      end
    end
  end

  initial begin
    vecs[0] = '{128, 256, 128, 256};
    vecs[1] = '{128, 256, 128, 256};
    vecs[2] = '{128, 256, 128, 256};
    vecs[3] = '{128, 256, 128, 256};
    vecs[4] = '{255, 256, 255, 256};
    vecs[5] = '{1,   256, 1,   256};
    vecs[6] = '{300, 600, 255, 600};
    vecs[7] = '{2,   4,   2,   4};
    vecs[8] = '{10,  1024, 10, 1024};
    vecs[9] = '{5,   20,  5,   20};

    RST          = 1'b1;
    pwm_in       = 1'b0;
    sample_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("rst_valid",   int'(sample_valid), 0);
    chk("rst_sample",  int'(sample_out),   0);
    chk("rst_period",  int'(period_out),   0);
    chk("rst_overrun", int'(overrun),      0);
    chk("rst_locked",  int'(locked),       0);

    // Table of frames, consumer always ready; the last one ends in a low timeout.
    sample_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      frame(vecs[i].high, vecs[i].period);
      push(vecs[i].exp_sample, vecs[i].exp_period);
      if (i == 0) chk("locked_before_first", int'(locked), 0);
      if (i == 2) chk("locked_after_first", int'(locked), 1);
    end
    push(0, 0);
    pin(1'b1, 1);
    pin(1'b0, 1100);
    chk("locked_after_timeout", int'(locked), 0);
    chk("overrun_none_ready", ovr_cnt, 0);
    chk("table_drained", sb.size(), 0);

    // Consumer stalled: two overwrites, then emit coinciding with a take.
    sample_ready = 1'b0;
    ovr0 = ovr_cnt;
    frame(100, 256);
    frame(50, 256);
    frame(60, 256);
    pin(1'b1, 5);
    chk("stall_valid",   int'(sample_valid), 1);
    chk("stall_sample",  int'(sample_out),   60);
    chk("stall_period",  int'(period_out),   256);
    chk("stall_overrun", ovr_cnt - ovr0,     2);
    push(60, 256);
    pin(1'b1, 75);
    pin(1'b0, 176);
    pwm_in = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    sample_ready = 1'b1;
    @(posedge CLK);
    #1;
    sample_ready = 1'b0;
    pin(1'b1, 3);
    chk("take_emit_valid",   int'(sample_valid), 1);
    chk("take_emit_sample",  int'(sample_out),   80);
    chk("take_emit_period",  int'(period_out),   256);
    chk("take_emit_overrun", ovr_cnt - ovr0,     2);
    push(80, 256);
    sample_ready = 1'b1;
    push(0, 0);
    pin(1'b0, 1100);
    chk("stall_drained", sb.size(), 0);

    // Steady high after lock gives one all-ones DC sample, steady low one zero sample.
    frame(128, 256);
    push(128, 256);
    frame(128, 256);
    push(128, 256);
    pin(1'b1, 20);
    chk("dc_locked_before", int'(locked), 1);
    push(255, 0);
    pin(1'b1, 1980);
    chk("dc_high_unlocked", int'(locked), 0);
    chk("dc_high_drained", sb.size(), 0);
    pin(1'b0, 10);
    push(0, 0);
    pin(1'b1, 1);
    pin(1'b0, 1100);
    chk("dc_low_drained", sb.size(), 0);

    // Glitch edge 3 cycles after a frame start is not a frame boundary.
    frame(128, 256);
    push(128, 256);
    pin(1'b1, 1);
    pin(1'b0, 2);
    pin(1'b1, 2);
    pin(1'b0, 251);
    push(3, 256);
    pin(1'b1, 1);
    push(0, 0);
    pin(1'b0, 1100);
    chk("glitch_drained", sb.size(), 0);

    // Reset in the middle of a frame.
    frame(128, 256);
    push(128, 256);
    pin(1'b1, 50);
    chk("pre_rst_sample", int'(sample_out), 128);
    pwm_in = 1'b0;
    RST    = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("midrst_valid",   int'(sample_valid), 0);
    chk("midrst_sample",  int'(sample_out),   0);
    chk("midrst_period",  int'(period_out),   0);
    chk("midrst_overrun", int'(overrun),      0);
    chk("midrst_locked",  int'(locked),       0);
    pin(1'b0, 20);
    frame(100, 256);
    chk("one_rise_no_sample", int'(sample_valid), 0);
    push(100, 256);
    pin(1'b1, 1);
    push(0, 0);
    pin(1'b0, 1100);
    chk("rst_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
